// File: rtl/acorn128_seq_ctrl.sv
// rtl/acorn128_seq_ctrl.sv - ACORN-128 job sequencer: phase FSM, step decode, input gating, tag capture
module acorn128_seq_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key,
  input  logic [127:0]     iv,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ks_in,
  output logic             step_en,
  output logic             ca,
  output logic             cb,
  output logic             mbit,
  output logic             enc_xor,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             done,
  output logic [127:0]     tag,
  output logic             tag_valid
);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_INIT   = 3'd1;
  localparam logic [2:0] PH_AD     = 3'd2;
  localparam logic [2:0] PH_ADPAD  = 3'd3;
  localparam logic [2:0] PH_ENC    = 3'd4;
  localparam logic [2:0] PH_ENCPAD = 3'd5;
  localparam logic [2:0] PH_FIN    = 3'd6;
  localparam logic [2:0] PH_DONE   = 3'd7;

  // Last-step indices of the fixed-length phases and the special INIT/FIN points
  localparam logic [LEN_W-1:0] INIT_LAST = LEN_W'(1791);
  localparam logic [LEN_W-1:0] PAD_LAST  = LEN_W'(255);
  localparam logic [LEN_W-1:0] FIN_LAST  = LEN_W'(767);
  localparam logic [LEN_W-1:0] TAG_FIRST = LEN_W'(640);
  localparam logic [LEN_W-1:0] PAD_CA_HI = LEN_W'(128);
  localparam logic [LEN_W-1:0] KEY_FLIP  = LEN_W'(256);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  logic [LEN_W-1:0] cnt;
  logic [127:0]     key_q;
  logic [127:0]     iv_q;
  logic [LEN_W-1:0] ad_len_q;
  logic [LEN_W-1:0] msg_len_q;

  logic             init_mbit;
  logic             pad_first;
  logic             pad_ca;
  logic             last_step;
  logic [2:0]       next_phase;

  assign busy = (phase != PH_IDLE) && (phase != PH_DONE);
  assign done = (phase == PH_DONE);

  // INIT message bit: key, then IV, then key with bit 0 flipped once, then key repeated
  always_comb begin
    init_mbit = key_q[cnt[6:0]];
    if (cnt[LEN_W-1:7] == (LEN_W-7)'(1)) begin
      init_mbit = iv_q[cnt[6:0]];
    end else if (cnt == KEY_FLIP) begin
      init_mbit = ~key_q[0];
    end
  end

  assign pad_first = (cnt == '0);
  assign pad_ca    = (cnt < PAD_CA_HI);

  // Per-step control decode; everything is zero unless the datapath steps this cycle
  always_comb begin
    step_en  = 1'b0;
    ca       = 1'b0;
    cb       = 1'b0;
    mbit     = 1'b0;
    in_ready = 1'b0;
    enc_xor  = 1'b0;
    case (phase)
      PH_INIT: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        mbit    = init_mbit;
      end
      PH_AD: begin
        in_ready = 1'b1;
        step_en  = in_valid;
        ca       = in_valid;
        cb       = in_valid;
        mbit     = in_valid & in_bit;
      end
      PH_ADPAD: begin
        step_en = 1'b1;
        ca      = pad_ca;
        cb      = 1'b1;
        mbit    = pad_first;
      end
      PH_ENC: begin
        in_ready = 1'b1;
        step_en  = in_valid;
        ca       = in_valid;
        mbit     = in_valid & in_bit;
        enc_xor  = in_valid;
      end
      PH_ENCPAD: begin
        step_en = 1'b1;
        ca      = pad_ca;
        mbit    = pad_first;
      end
      PH_FIN: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
      end
      default: begin
        step_en = 1'b0;
      end
    endcase
  end

  // Detect the final step of the current phase and pick the successor, skipping empty data phases
  always_comb begin
    last_step  = 1'b0;
    next_phase = PH_IDLE;
    case (phase)
      PH_INIT: begin
        last_step  = (cnt == INIT_LAST);
        next_phase = (ad_len_q == '0) ? PH_ADPAD : PH_AD;
      end
      PH_AD: begin
        last_step  = (cnt == ad_len_q - ONE);
        next_phase = PH_ADPAD;
      end
      PH_ADPAD: begin
        last_step  = (cnt == PAD_LAST);
        next_phase = (msg_len_q == '0) ? PH_ENCPAD : PH_ENC;
      end
      PH_ENC: begin
        last_step  = (cnt == msg_len_q - ONE);
        next_phase = PH_ENCPAD;
      end
      PH_ENCPAD: begin
        last_step  = (cnt == PAD_LAST);
        next_phase = PH_FIN;
      end
      PH_FIN: begin
        last_step  = (cnt == FIN_LAST);
        next_phase = PH_DONE;
      end
      default: begin
        last_step  = 1'b0;
        next_phase = PH_IDLE;
      end
    endcase
  end

  // Phase register and step counter; counter restarts at every phase entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else begin
      case (phase)
        PH_IDLE: begin
          cnt <= '0;
          if (start) begin
            phase <= PH_INIT;
          end
        end
        PH_DONE: begin
          phase <= PH_IDLE;
          cnt   <= '0;
        end
        default: begin
          if (step_en) begin
            if (last_step) begin
              phase <= next_phase;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
      endcase
    end
  end

  // Job parameters are captured only when a start is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      iv_q      <= '0;
      ad_len_q  <= '0;
      msg_len_q <= '0;
    end else if (phase == PH_IDLE && start) begin
      key_q     <= key;
      iv_q      <= iv;
      ad_len_q  <= ad_len;
      msg_len_q <= msg_len;
    end
  end

  // Tag shifts in keystream over the last 128 FIN steps and stays put until the next job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag       <= '0;
      tag_valid <= 1'b0;
    end else begin
      if (phase == PH_IDLE && start) begin
        tag       <= '0;
        tag_valid <= 1'b0;
      end else if (phase == PH_FIN && cnt >= TAG_FIRST) begin
        tag <= {ks_in, tag[127:1]};
      end else if (phase == PH_DONE) begin
        tag_valid <= 1'b1;
      end
    end
  end

endmodule
